// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared CPU constants, register-address type and MD-select encodings
package risc_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t R0 = '0;

  typedef enum logic [1:0] {
    MD_ALU = 2'd0,
    MD_MEM = 2'd1,
    MD_SLT = 2'd2
  } md_sel_t;

endpackage

// File: rtl/risc_scoreboard.sv
// rtl/risc_scoreboard.sv - per-register pending-write counters, overflow flag and hazard lookup
module risc_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_issue,
  input  logic [ADDR_W-1:0] i_issue_da,
  input  logic              i_retire,
  input  logic [ADDR_W-1:0] i_retire_da,
  input  logic [ADDR_W-1:0] i_aa,
  input  logic [ADDR_W-1:0] i_ba,
  output logic              o_hazard_a,
  output logic              o_hazard_b,
  output logic              o_ovf
);
  import risc_pkg::*;

  localparam int              NREG    = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_pend [NREG];
  logic             r_ovf;

  logic [CNT_W-1:0] w_pend_nxt [NREG];
  logic             w_ovf_set;
  logic             w_issue_ok;
  logic             w_retire_ok;
  logic [CNT_W-1:0] w_pend_a;
  logic [CNT_W-1:0] w_pend_b;
  logic             w_ret_hit_a;
  logic             w_ret_hit_b;

  assign w_issue_ok  = i_issue  && (i_issue_da  != ADDR_W'(R0));
  assign w_retire_ok = i_retire && (i_retire_da != ADDR_W'(R0));

  // Issue and retire hitting the same register cancel out.
  always_comb begin
    w_ovf_set = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      w_pend_nxt[r] = r_pend[r];
      if (w_issue_ok && (i_issue_da == ADDR_W'(r)) &&
          !(w_retire_ok && (i_retire_da == ADDR_W'(r)))) begin
        if (r_pend[r] == CNT_MAX) begin
          w_ovf_set = 1'b1;
        end else begin
          w_pend_nxt[r] = r_pend[r] + CNT_ONE;
        end
      end else if (w_retire_ok && (i_retire_da == ADDR_W'(r)) &&
                   !(w_issue_ok && (i_issue_da == ADDR_W'(r)))) begin
        if (r_pend[r] != '0) begin
          w_pend_nxt[r] = r_pend[r] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int r = 0; r < NREG; r++) begin
        r_pend[r] <= '0;
      end
      r_ovf <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        r_pend[r] <= w_pend_nxt[r];
      end
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // A retire this cycle is already bypassed, so it does not count as pending.
  assign w_pend_a    = r_pend[i_aa];
  assign w_pend_b    = r_pend[i_ba];
  assign w_ret_hit_a = w_retire_ok && (i_retire_da == i_aa);
  assign w_ret_hit_b = w_retire_ok && (i_retire_da == i_ba);

  assign o_hazard_a = !i_reset && (i_aa != ADDR_W'(R0)) &&
                      (w_ret_hit_a ? (w_pend_a > CNT_ONE) : (w_pend_a != '0));
  assign o_hazard_b = !i_reset && (i_ba != ADDR_W'(R0)) &&
                      (w_ret_hit_b ? (w_pend_b > CNT_ONE) : (w_pend_b != '0));
  assign o_ovf      = r_ovf;

endmodule

// File: rtl/risc_regfile.sv
// rtl/risc_regfile.sv - architectural register file with write-through bypass and RAW scoreboard
module risc_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WB_RW,
  input  logic [ADDR_W-1:0] WB_DA,
  input  logic [DATA_W-1:0] WB_Bus_D,
  input  logic [ADDR_W-1:0] DOF_AA,
  input  logic [ADDR_W-1:0] DOF_BA,
  input  logic              DOF_Issue,
  input  logic [ADDR_W-1:0] DOF_Issue_DA,
  output logic [DATA_W-1:0] DOF_Bus_A,
  output logic [DATA_W-1:0] DOF_Bus_B,
  output logic              DOF_Hazard_A,
  output logic              DOF_Hazard_B,
  output logic              SB_Ovf
);
  import risc_pkg::*;

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [NREG];

  logic              w_wr_en;
  logic [DATA_W-1:0] w_bus_a;
  logic [DATA_W-1:0] w_bus_b;

  assign w_wr_en = WB_RW && (WB_DA != ADDR_W'(R0));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        r_mem[r] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[WB_DA] <= WB_Bus_D;
    end
  end

  always_comb begin
    w_bus_a = '0;
    w_bus_b = '0;
    if (!reset && (DOF_AA != ADDR_W'(R0))) begin
      w_bus_a = (w_wr_en && (WB_DA == DOF_AA)) ? WB_Bus_D : r_mem[DOF_AA];
    end
    if (!reset && (DOF_BA != ADDR_W'(R0))) begin
      w_bus_b = (w_wr_en && (WB_DA == DOF_BA)) ? WB_Bus_D : r_mem[DOF_BA];
    end
  end

  assign DOF_Bus_A = w_bus_a;
  assign DOF_Bus_B = w_bus_b;

  risc_scoreboard #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_scoreboard (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_issue     (DOF_Issue),
    .i_issue_da  (DOF_Issue_DA),
    .i_retire    (WB_RW),
    .i_retire_da (WB_DA),
    .i_aa        (DOF_AA),
    .i_ba        (DOF_BA),
    .o_hazard_a  (DOF_Hazard_A),
    .o_hazard_b  (DOF_Hazard_B),
    .o_ovf       (SB_Ovf)
  );

endmodule

// File: tb/tb_risc_regfile.sv
// tb/tb_risc_regfile.sv - scoreboard bench for risc_regfile against a behavioural model
module tb_risc_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        WB_RW;
  logic [4:0]  WB_DA;
  logic [31:0] WB_Bus_D;
  logic [4:0]  DOF_AA;
  logic [4:0]  DOF_BA;
  logic        DOF_Issue;
  logic [4:0]  DOF_Issue_DA;
  logic [31:0] DOF_Bus_A;
  logic [31:0] DOF_Bus_B;
  logic        DOF_Hazard_A;
  logic        DOF_Hazard_B;
  logic        SB_Ovf;

  risc_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .WB_RW        (WB_RW),
    .WB_DA        (WB_DA),
    .WB_Bus_D     (WB_Bus_D),
    .DOF_AA       (DOF_AA),
    .DOF_BA       (DOF_BA),
    .DOF_Issue    (DOF_Issue),
    .DOF_Issue_DA (DOF_Issue_DA),
    .DOF_Bus_A    (DOF_Bus_A),
    .DOF_Bus_B    (DOF_Bus_B),
    .DOF_Hazard_A (DOF_Hazard_A),
    .DOF_Hazard_B (DOF_Hazard_B),
    .SB_Ovf       (SB_Ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] bus_a;
    logic [31:0] bus_b;
    logic        haz_a;
    logic        haz_b;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  bit          push_en = 1'b0;

  logic [31:0] m_regs [32];
  int          m_pend [32];
  bit          m_ovf = 1'b0;

  task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s %s: got %h, expected %h", tag, what, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.tag, "bus_a", DOF_Bus_A, e.bus_a);
        chk(e.tag, "bus_b", DOF_Bus_B, e.bus_b);
        chk(e.tag, "haz_a", {31'd0, DOF_Hazard_A}, {31'd0, e.haz_a});
        chk(e.tag, "haz_b", {31'd0, DOF_Hazard_B}, {31'd0, e.haz_b});
        chk(e.tag, "ovf",   {31'd0, SB_Ovf},       {31'd0, e.ovf});
      end
    end
  end

  function automatic logic [31:0] m_read(input bit rst, input bit rw, input int wa,
                                         input logic [31:0] wd, input int a);
    if (rst || a == 0) return 32'd0;
    if (rw && wa != 0 && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic m_hazard(input bit rst, input bit rw, input int wa, input int a);
    int outstanding;
    if (rst || a == 0) return 1'b0;
    outstanding = m_pend[a] - ((rw && wa != 0 && wa == a) ? 1 : 0);
    return outstanding > 0;
  endfunction

  // One cycle: drive inputs, queue the expected outputs, then advance the model at the edge.
  task automatic step(input string tag, input bit rst, input bit rw, input int wa,
                      input logic [31:0] wd, input int aa, input int ba,
                      input bit iss, input int ida);
    exp_t e;
    bit   do_iss, do_ret;
    reset        = rst;
    WB_RW        = rw;
    WB_DA        = 5'(wa);
    WB_Bus_D     = wd;
    DOF_AA       = 5'(aa);
    DOF_BA       = 5'(ba);
    DOF_Issue    = iss;
    DOF_Issue_DA = 5'(ida);
    if (push_en) begin
      e.tag   = tag;
      e.bus_a = m_read(rst, rw, wa, wd, aa);
      e.bus_b = m_read(rst, rw, wa, wd, ba);
      e.haz_a = m_hazard(rst, rw, wa, aa);
      e.haz_b = m_hazard(rst, rw, wa, ba);
      e.ovf   = m_ovf;
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[r] = 32'd0;
        m_pend[r] = 0;
      end
      m_ovf = 1'b0;
    end else begin
      do_iss = iss && ida != 0;
      do_ret = rw && wa != 0;
      if (do_ret) m_regs[wa] = wd;
      if (do_iss && do_ret && ida == wa) begin
        // net zero change
      end else begin
        if (do_iss) begin
          if (m_pend[ida] == 3) m_ovf = 1'b1;
          else m_pend[ida] = m_pend[ida] + 1;
        end
        if (do_ret && m_pend[wa] > 0) m_pend[wa] = m_pend[wa] - 1;
      end
    end
    #1;
  endtask

  task automatic idle(input string tag, input int aa, input int ba);
    step(tag, 1'b0, 1'b0, 0, 32'd0, aa, ba, 1'b0, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; WB_RW = 1'b0; WB_DA = '0; WB_Bus_D = '0;
    DOF_AA = '0; DOF_BA = '0; DOF_Issue = 1'b0; DOF_Issue_DA = '0;
    @(posedge clk); #1;
    step("rst0", 1'b1, 1'b0, 0, 32'd0, 5, 9, 1'b0, 0);
    push_en = 1'b1;
    step("rst1", 1'b1, 1'b1, 5, 32'hAAAA5555, 5, 9, 1'b1, 5);

    step("wr_r5",    1'b0, 1'b1, 5, 32'hDEADBEEF, 0, 0, 1'b0, 0);
    idle("rd_r5", 5, 5);
    step("rst_rd5",  1'b1, 1'b0, 0, 32'd0, 5, 5, 1'b0, 0);
    idle("rd_r5_cl", 5, 0);

    step("bypass7",  1'b0, 1'b1, 7, 32'h12345678, 7, 7, 1'b0, 0);
    idle("rd_r7", 7, 0);

    step("wr_r0",    1'b0, 1'b1, 0, 32'hFFFFFFFF, 0, 0, 1'b0, 0);
    step("iss_r0",   1'b0, 1'b0, 0, 32'd0, 0, 0, 1'b1, 0);
    idle("haz_r0", 0, 0);

    step("iss_r3",   1'b0, 1'b0, 0, 32'd0, 3, 0, 1'b1, 3);
    idle("haz_r3", 3, 3);
    step("wb_r3",    1'b0, 1'b1, 3, 32'hCAFEF00D, 3, 0, 1'b0, 0);
    idle("clr_r3", 3, 3);

    step("iss4a",    1'b0, 1'b0, 0, 32'd0, 4, 0, 1'b1, 4);
    step("iss4b",    1'b0, 1'b0, 0, 32'd0, 4, 0, 1'b1, 4);
    step("iss_ret4", 1'b0, 1'b1, 4, 32'h44, 4, 4, 1'b1, 4);
    step("ret4a",    1'b0, 1'b1, 4, 32'h45, 4, 4, 1'b0, 0);
    step("ret4b",    1'b0, 1'b1, 4, 32'h46, 4, 4, 1'b0, 0);
    idle("clr_r4", 4, 4);

    for (int i = 0; i < 4; i++) step("iss9", 1'b0, 1'b0, 0, 32'd0, 0, 9, 1'b1, 9);
    idle("ovf9a", 9, 9);
    idle("ovf9b", 9, 0);
    step("ret9",     1'b0, 1'b1, 9, 32'h99, 9, 9, 1'b0, 0);
    step("rst_ovf",  1'b1, 1'b0, 0, 32'd0, 9, 9, 1'b0, 0);
    idle("ovf_cl", 9, 9);

    for (int i = 0; i < 400; i++) begin
      n = int'($urandom_range(0, 99));
      step("rand", n < 2, $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)), $urandom,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
           $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)));
    end

    idle("drain", 0, 0);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
